tcam_lookup_ctrl: RTL and testbench

Request sequencer that sits directly upstream of the tcam block and drives its write/search port.
- Accepts a ready/valid stream of write and search requests and buffers them in order.
- Issues each request to the TCAM with correct timing and captures found/saddr/sdata.
- Returns search results on a ready/valid response stream and keeps hit/miss statistics.

---
 rtl/tcam_pkg.sv | 24 ++
 rtl/tcam_lookup_ctrl_if.sv | 35 +++
 rtl/tcam_req_fifo.sv | 71 +++++++
 rtl/tcam_lookup_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_tcam_lookup_ctrl.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tcam_pkg.sv
// tcam_pkg: types and constants shared by the TCAM lookup controller slice.
//   TCAM_W / TCAM_N / TCAM_AW : word width, entry count, entry address width.
//   state_t : controller FSM states.
//   req_t   : one queued request (write flag, entry address, word or key).
package tcam_pkg;

  localparam int TCAM_W  = 8;
  localparam int TCAM_N  = 8;
  localparam int TCAM_AW = $clog2(TCAM_N);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    SEARCH = 2'd2,
    RESP   = 2'd3
  } state_t;

  typedef struct packed {
    logic               write;
    logic [TCAM_AW-1:0] addr;
    logic [TCAM_W-1:0]  data;
  } req_t;

endpackage

// File: rtl/tcam_lookup_ctrl_if.sv
// tcam_lookup_ctrl_if: request and response streams of the lookup controller.
//   req_valid/req_ready/req_write/req_addr/req_data : request stream
//   rsp_valid/rsp_ready/rsp_found/rsp_addr/rsp_data : search result stream
//   modport master : request producer / response consumer
//   modport slave  : the controller
interface tcam_lookup_ctrl_if
  import tcam_pkg::*;
#(
  parameter int W  = TCAM_W,
  parameter int AW = TCAM_AW
);

  logic          req_valid;
  logic          req_ready;
  logic          req_write;
  logic [AW-1:0] req_addr;
  logic [W-1:0]  req_data;

  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_found;
  logic [AW-1:0] rsp_addr;
  logic [W-1:0]  rsp_data;

  modport master (
    output req_valid, req_write, req_addr, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_found, rsp_addr, rsp_data
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_found, rsp_addr, rsp_data
  );

endinterface

// File: rtl/tcam_req_fifo.sv
// tcam_req_fifo: synchronous in-order FIFO of req_t entries.
//   clk, rst : clock, asynchronous active-high reset (clears pointers/count)
//   push/din : write an entry (ignored while full)
//   pop/dout : dout shows the head; pop advances it (ignored while empty)
//   full, empty, count : occupancy status
module tcam_req_fifo
  import tcam_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  req_t                       din,
  input  logic                       pop,
  output req_t                       dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW   = $clog2(DEPTH);
  localparam int CNTW = $clog2(DEPTH+1);

  req_t            mem_r [DEPTH];
  logic [PW-1:0]   wr_ptr_r;
  logic [PW-1:0]   rd_ptr_r;
  logic [CNTW-1:0] count_r;
  logic            push_s;
  logic            pop_s;

  assign full  = (count_r == CNTW'(DEPTH));
  assign empty = (count_r == CNTW'(0));
  assign count = count_r;
  assign dout  = mem_r[rd_ptr_r];

  // Qualify push/pop with occupancy so overflow/underflow can never occur.
  always_comb begin
    push_s = push && !full;
    pop_s  = pop && !empty;
  end

  // Storage array; no reset needed since only occupied slots are ever read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers wrap naturally (DEPTH is a power of two); simultaneous push/pop keeps count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= PW'(0);
      rd_ptr_r <= PW'(0);
      count_r  <= CNTW'(0);
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNTW'(1);
        2'b01:   count_r <= count_r - CNTW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/tcam_lookup_ctrl.sv
// tcam_lookup_ctrl: in-order request sequencer in front of a TCAM.
//   clk, rst   : clock, asynchronous active-high reset
//   bus        : request stream in, search result stream out (slave modport)
//   tcam_we/tcam_waddr/tcam_data/tcam_search : TCAM write/search port
//   tcam_found/tcam_saddr/tcam_sdata         : TCAM search result
//   hit_cnt/miss_cnt : saturating search statistics
//   busy       : FSM active or requests queued
// Requests are buffered in a FIFO and executed one at a time: a write takes one
// cycle, a search holds the key for SRCH_LAT+1 cycles and captures the result on
// the last one, then waits in RESP until the result is taken.
module tcam_lookup_ctrl
  import tcam_pkg::*;
#(
  parameter int W        = TCAM_W,
  parameter int N        = TCAM_N,
  parameter int DEPTH    = 4,
  parameter int SRCH_LAT = 1,
  parameter int CW       = 16,
  localparam int AW      = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst,
  tcam_lookup_ctrl_if.slave    bus,
  output logic                 tcam_we,
  output logic [AW-1:0]        tcam_waddr,
  output logic [W-1:0]         tcam_data,
  output logic                 tcam_search,
  input  logic                 tcam_found,
  input  logic [AW-1:0]        tcam_saddr,
  input  logic [W-1:0]         tcam_sdata,
  output logic [CW-1:0]        hit_cnt,
  output logic [CW-1:0]        miss_cnt,
  output logic                 busy
);

  localparam int LW   = $clog2(SRCH_LAT+1);
  localparam int CNTW = $clog2(DEPTH+1);

  state_t          state_r;
  state_t          state_nxt_s;
  req_t            work_r;
  logic [LW-1:0]   lat_cnt_r;
  logic            rsp_found_r;
  logic [AW-1:0]   rsp_addr_r;
  logic [W-1:0]    rsp_data_r;
  logic [CW-1:0]   hit_cnt_r;
  logic [CW-1:0]   miss_cnt_r;

  req_t            fifo_din_s;
  req_t            fifo_dout_s;
  logic            fifo_full_s;
  logic            fifo_empty_s;
  logic [CNTW-1:0] fifo_count_s;
  logic            pop_s;
  logic            last_s;

  logic            tcam_we_s;
  logic            tcam_search_s;
  logic [AW-1:0]   tcam_waddr_s;
  logic [W-1:0]    tcam_data_s;

  assign fifo_din_s = '{write: bus.req_write, addr: bus.req_addr, data: bus.req_data};

  tcam_req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.req_valid),
    .din   (fifo_din_s),
    .pop   (pop_s),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s),
    .count (fifo_count_s)
  );

  // Heads are only taken while idle, which serialises all TCAM traffic.
  assign pop_s  = (state_r == IDLE) && !fifo_empty_s;
  assign last_s = (state_r == SEARCH) && (lat_cnt_r == LW'(0));

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (!fifo_empty_s) begin
          state_nxt_s = fifo_dout_s.write ? WRITE : SEARCH;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WRITE: state_nxt_s = IDLE;
      SEARCH: begin
        if (lat_cnt_r == LW'(0)) begin
          state_nxt_s = RESP;
        end else begin
          state_nxt_s = SEARCH;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM outputs: decoded only from registers, so the TCAM port is glitch-free.
  always_comb begin
    tcam_we_s     = 1'b0;
    tcam_search_s = 1'b0;
    tcam_waddr_s  = AW'(0);
    tcam_data_s   = W'(0);
    case (state_r)
      WRITE: begin
        tcam_we_s    = 1'b1;
        tcam_waddr_s = work_r.addr;
        tcam_data_s  = work_r.data;
      end
      SEARCH: begin
        tcam_search_s = 1'b1;
        tcam_data_s   = work_r.data;
      end
      default: begin
        tcam_we_s     = 1'b0;
        tcam_search_s = 1'b0;
      end
    endcase
  end

  // Working request and the search down-counter (SRCH_LAT..0, capture at 0).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work_r    <= '{write: 1'b0, addr: AW'(0), data: W'(0)};
      lat_cnt_r <= LW'(0);
    end else begin
      if (pop_s) begin
        work_r    <= fifo_dout_s;
        lat_cnt_r <= LW'(SRCH_LAT);
      end else if ((state_r == SEARCH) && (lat_cnt_r != LW'(0))) begin
        lat_cnt_r <= lat_cnt_r - LW'(1);
      end
    end
  end

  // Result capture and saturating hit/miss statistics on the last search cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_found_r <= 1'b0;
      rsp_addr_r  <= AW'(0);
      rsp_data_r  <= W'(0);
      hit_cnt_r   <= CW'(0);
      miss_cnt_r  <= CW'(0);
    end else if (last_s) begin
      rsp_found_r <= tcam_found;
      rsp_addr_r  <= tcam_saddr;
      rsp_data_r  <= tcam_sdata;
      if (tcam_found) begin
        if (hit_cnt_r != {CW{1'b1}}) begin
          hit_cnt_r <= hit_cnt_r + CW'(1);
        end
      end else begin
        if (miss_cnt_r != {CW{1'b1}}) begin
          miss_cnt_r <= miss_cnt_r + CW'(1);
        end
      end
    end
  end

  assign tcam_we       = tcam_we_s;
  assign tcam_search   = tcam_search_s;
  assign tcam_waddr    = tcam_waddr_s;
  assign tcam_data     = tcam_data_s;
  assign bus.req_ready = !fifo_full_s;
  assign bus.rsp_valid = (state_r == RESP);
  assign bus.rsp_found = rsp_found_r;
  assign bus.rsp_addr  = rsp_addr_r;
  assign bus.rsp_data  = rsp_data_r;
  assign hit_cnt       = hit_cnt_r;
  assign miss_cnt      = miss_cnt_r;
  assign busy          = (state_r != IDLE) || (fifo_count_s != CNTW'(0));

endmodule

// File: tb/tb_tcam_lookup_ctrl.sv
// tb_tcam_lookup_ctrl: directed bench for tcam_lookup_ctrl.
// Instance a: SRCH_LAT=1, CW=16. Instance b: SRCH_LAT=3, CW=2.
// Each instance drives a behavioural TCAM (exact match, lowest index wins)
// whose result appears SRCH_LAT clocks after the key is sampled.
module tb_tcam_lookup_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  tcam_lookup_ctrl_if #(.W(8), .AW(3)) ifa ();
  tcam_lookup_ctrl_if #(.W(8), .AW(3)) ifb ();

  logic        tcam_we_a, tcam_search_a, tcam_found_a, busy_a;
  logic [2:0]  tcam_waddr_a, tcam_saddr_a;
  logic [7:0]  tcam_data_a, tcam_sdata_a;
  logic [15:0] hit_a, miss_a;

  logic        tcam_we_b, tcam_search_b, tcam_found_b, busy_b;
  logic [2:0]  tcam_waddr_b, tcam_saddr_b;
  logic [7:0]  tcam_data_b, tcam_sdata_b;
  logic [1:0]  hit_b, miss_b;

  tcam_lookup_ctrl #(.W(8), .N(8), .DEPTH(4), .SRCH_LAT(1), .CW(16)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa),
    .tcam_we(tcam_we_a), .tcam_waddr(tcam_waddr_a), .tcam_data(tcam_data_a),
    .tcam_search(tcam_search_a), .tcam_found(tcam_found_a),
    .tcam_saddr(tcam_saddr_a), .tcam_sdata(tcam_sdata_a),
    .hit_cnt(hit_a), .miss_cnt(miss_a), .busy(busy_a)
  );

  tcam_lookup_ctrl #(.W(8), .N(8), .DEPTH(4), .SRCH_LAT(3), .CW(2)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb),
    .tcam_we(tcam_we_b), .tcam_waddr(tcam_waddr_b), .tcam_data(tcam_data_b),
    .tcam_search(tcam_search_b), .tcam_found(tcam_found_b),
    .tcam_saddr(tcam_saddr_b), .tcam_sdata(tcam_sdata_b),
    .hit_cnt(hit_b), .miss_cnt(miss_b), .busy(busy_b)
  );

  // ---------------- behavioural TCAM models ----------------
  function automatic logic [11:0] tmatch(input logic [7:0] m [8], input logic [7:0] v,
                                         input logic [7:0] key);
    logic [11:0] r;
    r = 12'h000;
    for (int i = 7; i >= 0; i--) begin
      if (v[i] && (m[i] == key)) r = {1'b1, 3'(i), m[i]};
    end
    return r;
  endfunction

  logic [7:0]  mem_a [8];
  logic [7:0]  vld_a;
  logic [11:0] res_a;
  logic [7:0]  mem_b [8];
  logic [7:0]  vld_b;
  logic [11:0] res_b1, res_b2, res_b3;

  // TCAM a: one-stage result
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_a <= 8'h00;
      res_a <= 12'h000;
    end else begin
      if (tcam_we_a) begin
        mem_a[tcam_waddr_a] <= tcam_data_a;
        vld_a[tcam_waddr_a] <= 1'b1;
      end
      if (tcam_search_a) res_a <= tmatch(mem_a, vld_a, tcam_data_a);
    end
  end
  assign {tcam_found_a, tcam_saddr_a, tcam_sdata_a} = res_a;

  // TCAM b: three-stage result pipeline
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_b  <= 8'h00;
      res_b1 <= 12'h000;
      res_b2 <= 12'h000;
      res_b3 <= 12'h000;
    end else begin
      if (tcam_we_b) begin
        mem_b[tcam_waddr_b] <= tcam_data_b;
        vld_b[tcam_waddr_b] <= 1'b1;
      end
      if (tcam_search_b) res_b1 <= tmatch(mem_b, vld_b, tcam_data_b);
      res_b2 <= res_b1;
      res_b3 <= res_b2;
    end
  end
  assign {tcam_found_b, tcam_saddr_b, tcam_sdata_b} = res_b3;

  // ---------------- monitors (mid-cycle) ----------------
  logic [10:0] we_log [$];
  int          overlap = 0;
  int          run_b = 0;
  int          last_run_b = 0;
  logic [7:0]  first_b = 8'h00;
  logic        stable_b = 1'b1;
  logic [11:0] last_out_b = 12'h000;

  always @(negedge clk) begin
    if (tcam_we_a) we_log.push_back({tcam_waddr_a, tcam_data_a});
    if ((tcam_we_a && tcam_search_a) || (tcam_we_b && tcam_search_b)) overlap++;
    if (tcam_search_b) begin
      if (run_b == 0) begin
        first_b  = tcam_data_b;
        stable_b = 1'b1;
      end else if (tcam_data_b != first_b) begin
        stable_b = 1'b0;
      end
      run_b++;
      last_out_b = {tcam_found_b, tcam_saddr_b, tcam_sdata_b};
    end else if (run_b != 0) begin
      last_run_b = run_b;
      run_b = 0;
    end
  end

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input int s, input logic wr, input logic [2:0] a, input logic [7:0] d);
    int t;
    t = 0;
    if (s == 0) begin
      ifa.req_valid = 1'b1; ifa.req_write = wr; ifa.req_addr = a; ifa.req_data = d;
    end else begin
      ifb.req_valid = 1'b1; ifb.req_write = wr; ifb.req_addr = a; ifb.req_data = d;
    end
    while (((s == 0) ? !ifa.req_ready : !ifb.req_ready) && t < 200) begin
      @(posedge clk); #1; t++;
    end
    chk("push_accept", 32'(t < 200), 32'd1);
    @(posedge clk); #1;
    if (s == 0) ifa.req_valid = 1'b0;
    else ifb.req_valid = 1'b0;
  endtask

  task automatic get_rsp(input int s, output logic f, output logic [2:0] a, output logic [7:0] d);
    int t;
    t = 0;
    if (s == 0) ifa.rsp_ready = 1'b1;
    else ifb.rsp_ready = 1'b1;
    while (!((s == 0) ? ifa.rsp_valid : ifb.rsp_valid) && t < 200) begin
      @(posedge clk); #1; t++;
    end
    chk("rsp_arrive", 32'(t < 200), 32'd1);
    if (s == 0) begin f = ifa.rsp_found; a = ifa.rsp_addr; d = ifa.rsp_data; end
    else begin f = ifb.rsp_found; a = ifb.rsp_addr; d = ifb.rsp_data; end
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input int s);
    int t;
    t = 0;
    while (((s == 0) ? busy_a : busy_b) && t < 200) begin
      @(posedge clk); #1; t++;
    end
    chk("idle_reached", 32'(t < 200), 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic       f;
    logic [2:0] a;
    logic [7:0] d;
    int         n;
    int         ready_hi;

    ifa.req_valid = 1'b0; ifa.req_write = 1'b0; ifa.req_addr = 3'd0; ifa.req_data = 8'h00;
    ifa.rsp_ready = 1'b1;
    ifb.req_valid = 1'b0; ifb.req_write = 1'b0; ifb.req_addr = 3'd0; ifb.req_data = 8'h00;
    ifb.rsp_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy_a, 0);
    chk("rst_rsp_valid", ifa.rsp_valid, 0);
    chk("rst_we", tcam_we_a, 0);
    chk("rst_hit", hit_a, 0);
    rst = 1'b0;

    // 1: async reset while 3 requests queued behind a stalled response
    ifa.rsp_ready = 1'b0;
    push(0, 1'b0, 3'd0, 8'h11);
    push(0, 1'b1, 3'd1, 8'h01);
    push(0, 1'b1, 3'd2, 8'h02);
    push(0, 1'b1, 3'd4, 8'h04);
    chk("t1_stalled_valid", ifa.rsp_valid, 1);
    chk("t1_pre_miss", miss_a, 1);
    #2; rst = 1'b1; #1;
    chk("t1_search_off", tcam_search_a, 0);
    chk("t1_valid_off", ifa.rsp_valid, 0);
    chk("t1_busy_off", busy_a, 0);
    chk("t1_miss_clr", miss_a, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    ifa.rsp_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("t1_busy_after", busy_a, 0);
    chk("t1_no_we", we_log.size(), 0);

    // 2: write then search (hit), with latency check
    push(0, 1'b1, 3'd0, 8'b01010101);
    push(0, 1'b1, 3'd3, 8'b01011101);
    wait_idle(0);
    chk("t2_we_cnt", we_log.size(), 2);
    chk("t2_we0", we_log[0], {3'd0, 8'h55});
    chk("t2_we1", we_log[1], {3'd3, 8'h5D});
    push(0, 1'b0, 3'd0, 8'b01011101);
    n = 0;
    while (!ifa.rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
    chk("t2_latency", n, 3);
    get_rsp(0, f, a, d);
    chk("t2_found", f, 1);
    chk("t2_addr", a, 3);
    chk("t2_data", d, 8'h5D);
    chk("t2_hit", hit_a, 1);

    // 3: miss with held response
    ifa.rsp_ready = 1'b0;
    push(0, 1'b0, 3'd0, 8'hFF);
    n = 0;
    while (!ifa.rsp_valid && n < 50) begin @(posedge clk); #1; n++; end
    f = ifa.rsp_found; a = ifa.rsp_addr; d = ifa.rsp_data;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (ifa.rsp_valid && ifa.rsp_found == f && ifa.rsp_addr == a && ifa.rsp_data == d) n++;
    end
    chk("t3_hold", n, 5);
    chk("t3_found", f, 0);
    chk("t3_miss", miss_a, 1);
    ifa.rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("t3_drop", ifa.rsp_valid, 0);

    // 4: FIFO full under backpressure, then in-order drain
    ifa.rsp_ready = 1'b0;
    push(0, 1'b0, 3'd0, 8'h55);
    push(0, 1'b1, 3'd5, 8'hA0);
    push(0, 1'b0, 3'd0, 8'hA0);
    push(0, 1'b0, 3'd0, 8'h5D);
    push(0, 1'b1, 3'd0, 8'h5D);
    chk("t4_full", ifa.req_ready, 0);
    ifa.req_valid = 1'b1; ifa.req_write = 1'b0; ifa.req_addr = 3'd0; ifa.req_data = 8'h5D;
    ready_hi = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (ifa.req_ready) ready_hi++;
    end
    chk("t4_stays_full", ready_hi, 0);
    fork
      push(0, 1'b0, 3'd0, 8'h5D);
      begin
        logic       ff;
        logic [2:0] aa;
        logic [7:0] dd;
        get_rsp(0, ff, aa, dd);
        chk("t4_r1", {ff, aa, dd}, {1'b1, 3'd0, 8'h55});
        get_rsp(0, ff, aa, dd);
        chk("t4_r2", {ff, aa, dd}, {1'b1, 3'd5, 8'hA0});
        get_rsp(0, ff, aa, dd);
        chk("t4_r3", {ff, aa, dd}, {1'b1, 3'd3, 8'h5D});
        get_rsp(0, ff, aa, dd);
        chk("t4_r4", {ff, aa, dd}, {1'b1, 3'd0, 8'h5D});
      end
    join
    wait_idle(0);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (ifa.rsp_valid) n++;
    end
    chk("t4_no_extra", n, 0);
    chk("t4_hit", hit_a, 5);
    chk("t4_miss", miss_a, 1);
    chk("t4_we_cnt", we_log.size(), 4);
    chk("t4_we2", we_log[2], {3'd5, 8'hA0});
    chk("t4_we3", we_log[3], {3'd0, 8'h5D});

    // 5: SRCH_LAT=3 search timing and capture point
    push(1, 1'b1, 3'd2, 8'h33);
    push(1, 1'b1, 3'd6, 8'h77);
    push(1, 1'b0, 3'd0, 8'h33);
    get_rsp(1, f, a, d);
    chk("t5_first", {f, a, d}, {1'b1, 3'd2, 8'h33});
    push(1, 1'b0, 3'd0, 8'h77);
    get_rsp(1, f, a, d);
    chk("t5_rsp", {f, a, d}, {1'b1, 3'd6, 8'h77});
    chk("t5_run_len", last_run_b, 4);
    chk("t5_key_stable", stable_b, 1);
    chk("t5_capture", last_out_b, {f, a, d});

    // 6: saturation at CW=2
    push(1, 1'b0, 3'd0, 8'h33);
    get_rsp(1, f, a, d);
    chk("t6_hit3", hit_b, 3);
    push(1, 1'b0, 3'd0, 8'h77);
    get_rsp(1, f, a, d);
    push(1, 1'b0, 3'd0, 8'h33);
    get_rsp(1, f, a, d);
    chk("t6_hit_sat", hit_b, 3);
    chk("t6_miss", miss_b, 0);

    chk("we_search_overlap", overlap, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
